// File: rtl/w4823_fir_pkg.sv
// rtl/w4823_fir_pkg.sv - shared constants and state type for the W4823 FIR sequencer
package w4823_fir_pkg;
    localparam int FIR_AW      = 6;
    localparam int FIR_DW      = 16;
    localparam int FIR_CW      = 17;
    localparam int FIR_ACCW    = FIR_DW + FIR_CW + FIR_AW;
    localparam int FIR_MAC_LAT = 2;
    localparam int FIR_NTAPS   = 2 ** FIR_AW;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;
endpackage

// File: rtl/w4823_fir_seq_if.sv
// rtl/w4823_fir_seq_if.sv - sample, coefficient-load, memory and MAC signals of the FIR sequencer
interface w4823_fir_seq_if
    import w4823_fir_pkg::*;
#(
    parameter int AW   = FIR_AW,
    parameter int DW   = FIR_DW,
    parameter int CW   = FIR_CW,
    parameter int ACCW = FIR_ACCW
);
    logic            sample_stb;
    logic [DW-1:0]   din;
    logic            cload_req;
    logic [AW-1:0]   caddr;
    logic [CW-1:0]   cin;
    logic            cload_ack;
    logic            dmem_we;
    logic [AW-1:0]   dmem_waddr;
    logic [DW-1:0]   dmem_wdata;
    logic [AW-1:0]   dmem_raddr;
    logic            cmem_we;
    logic [AW-1:0]   cmem_addr;
    logic [CW-1:0]   cmem_wdata;
    logic            mac_en;
    logic            mac_clr;
    logic [ACCW-1:0] mac_acc;
    logic [ACCW-1:0] dout;
    logic            valid;
    logic            busy;
    logic            overrun;

    modport master (
        input  sample_stb, din, cload_req, caddr, cin, mac_acc,
        output cload_ack, dmem_we, dmem_waddr, dmem_wdata, dmem_raddr,
               cmem_we, cmem_addr, cmem_wdata, mac_en, mac_clr,
               dout, valid, busy, overrun
    );

    modport slave (
        output sample_stb, din, cload_req, caddr, cin, mac_acc,
        input  cload_ack, dmem_we, dmem_waddr, dmem_wdata, dmem_raddr,
               cmem_we, cmem_addr, cmem_wdata, mac_en, mac_clr,
               dout, valid, busy, overrun
    );
endinterface

// File: rtl/w4823_fir_addr_gen.sv
// rtl/w4823_fir_addr_gen.sv - tap counter with terminal count and circular delay-line read address
module w4823_fir_addr_gen #(
    parameter int AW    = 6,
    parameter int NTAPS = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          step,
    input  logic [AW-1:0] wptr,
    output logic [AW-1:0] k,
    output logic          last,
    output logic [AW-1:0] raddr
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k <= '0;
        end else if (clr) begin
            k <= '0;
        end else if (step) begin
            k <= k + 1'b1;
        end
    end

    assign last  = (k == AW'(NTAPS - 1));
    // Subtraction wraps modulo 2**AW, which is exactly the circular buffer walk-back.
    assign raddr = wptr - k;
endmodule

// File: rtl/w4823_fir_seq.sv
// rtl/w4823_fir_seq.sv - sequencer for the time-multiplexed W4823 FIR datapath
module w4823_fir_seq
    import w4823_fir_pkg::*;
#(
    parameter int AW      = FIR_AW,
    parameter int DW      = FIR_DW,
    parameter int CW      = FIR_CW,
    parameter int ACCW    = FIR_ACCW,
    parameter int MAC_LAT = FIR_MAC_LAT
) (
    input logic             clk,
    input logic             rst,
    w4823_fir_seq_if.master bus
);
    localparam int NTAPS = 2 ** AW;

    state_t          state, state_nx;
    logic [AW-1:0]   wptr, k, raddr;
    logic            k_last, k_clr, k_step, run_cyc;
    logic            dmem_we_c, cmem_we_c, cload_ack_c;
    logic [AW-1:0]   dmem_waddr_c, cmem_addr_c;
    logic [DW-1:0]   dmem_wdata_c;
    logic [CW-1:0]   cmem_wdata_c;
    logic            mac_en_r, mac_clr_r, valid_r;
    logic [ACCW-1:0] dout_r;

    w4823_fir_addr_gen #(.AW(AW), .NTAPS(NTAPS)) u_addr_gen (
        .clk   (clk),
        .rst   (rst),
        .clr   (k_clr),
        .step  (k_step),
        .wptr  (wptr),
        .k     (k),
        .last  (k_last),
        .raddr (raddr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_INIT;
        end else begin
            state <= state_nx;
        end
    end

    // k doubles as the INIT clear address and the DRAIN wait counter.
    always_comb begin
        state_nx     = state;
        k_clr        = 1'b0;
        k_step       = 1'b0;
        run_cyc      = 1'b0;
        dmem_we_c    = 1'b0;
        dmem_waddr_c = '0;
        dmem_wdata_c = '0;
        cmem_we_c    = 1'b0;
        cmem_addr_c  = '0;
        cmem_wdata_c = '0;
        cload_ack_c  = 1'b0;
        unique case (state)
            ST_INIT: begin
                dmem_we_c    = 1'b1;
                dmem_waddr_c = k;
                k_step       = 1'b1;
                if (k_last) state_nx = ST_IDLE;
            end
            ST_IDLE: begin
                k_clr = 1'b1;
                if (bus.sample_stb) begin
                    dmem_we_c    = 1'b1;
                    dmem_waddr_c = wptr;
                    dmem_wdata_c = bus.din;
                    state_nx     = ST_RUN;
                end else if (bus.cload_req) begin
                    cmem_we_c    = 1'b1;
                    cmem_addr_c  = bus.caddr;
                    cmem_wdata_c = bus.cin;
                    cload_ack_c  = 1'b1;
                end
            end
            ST_RUN: begin
                k_step      = 1'b1;
                run_cyc     = 1'b1;
                cmem_addr_c = k;
                if (k_last) state_nx = ST_DRAIN;
            end
            ST_DRAIN: begin
                k_step = 1'b1;
                if (k == AW'(MAC_LAT - 1)) state_nx = ST_DONE;
            end
            ST_DONE: begin
                k_clr    = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_INIT;
        endcase
    end

    // Strobes are delayed one cycle so they line up with the synchronous memory read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mac_en_r  <= 1'b0;
            mac_clr_r <= 1'b0;
            valid_r   <= 1'b0;
            dout_r    <= '0;
            wptr      <= '0;
        end else begin
            mac_en_r  <= run_cyc;
            mac_clr_r <= run_cyc && (k == '0);
            valid_r   <= (state == ST_DONE);
            if (state == ST_DONE) begin
                dout_r <= bus.mac_acc;
                wptr   <= wptr + 1'b1;
            end
        end
    end

    // Reset also masks the INIT-state outputs so nothing is driven while rst is held.
    assign bus.dmem_we    = !rst && dmem_we_c;
    assign bus.dmem_waddr = dmem_waddr_c;
    assign bus.dmem_wdata = dmem_wdata_c;
    assign bus.dmem_raddr = (state == ST_RUN) ? raddr : '0;
    assign bus.cmem_we    = cmem_we_c;
    assign bus.cmem_addr  = cmem_addr_c;
    assign bus.cmem_wdata = cmem_wdata_c;
    assign bus.cload_ack  = cload_ack_c;
    assign bus.mac_en     = mac_en_r;
    assign bus.mac_clr    = mac_clr_r;
    assign bus.dout       = dout_r;
    assign bus.valid      = valid_r;
    assign bus.busy       = !rst && (state != ST_IDLE);
    assign bus.overrun    = !rst && bus.sample_stb && (state != ST_IDLE);
endmodule

// File: tb/tb_w4823_fir_seq.sv
// tb/tb_w4823_fir_seq.sv - randomized self-checking bench for the W4823 FIR sequencer
module tb_w4823_fir_seq;
    localparam int AW = 6, DW = 16, CW = 17, ACCW = 39, NT = 64, MAC_LAT = 2;
    localparam int LAT = NT + MAC_LAT + 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    w4823_fir_seq_if #(.AW(AW), .DW(DW), .CW(CW), .ACCW(ACCW)) bus ();
    w4823_fir_seq #(.AW(AW), .DW(DW), .CW(CW), .ACCW(ACCW), .MAC_LAT(MAC_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // External memories and a two-stage MAC around the sequencer
    logic [DW-1:0]          dmem [NT];
    logic [CW-1:0]          cmem [NT];
    logic signed [DW-1:0]   drd;
    logic signed [CW-1:0]   crd;
    logic signed [ACCW-1:0] prod, acc1, acc2;
    assign prod        = drd * crd;
    assign bus.mac_acc = acc2;
    always @(posedge clk) begin
        if (bus.dmem_we) dmem[bus.dmem_waddr] <= bus.dmem_wdata;
        if (bus.cmem_we) cmem[bus.cmem_addr] <= bus.cmem_wdata;
        drd  <= dmem[bus.dmem_raddr];
        crd  <= cmem[bus.cmem_addr];
        if (bus.mac_en) acc1 <= bus.mac_clr ? prod : acc1 + prod;
        acc2 <= acc1;
    end

    // Reference: y[n] = sum_k coef[k] * x[n-k], history cleared by reset
    int coef_m [NT];
    int hist [$];
    int wptr_m;
    int n_checks = 0;
    int n_fail = 0;

    function automatic logic [ACCW-1:0] ref_out();
        longint s = 0;
        for (int i = 0; i < NT; i++) s += longint'(coef_m[i]) * longint'(hist[i]);
        return ACCW'(s);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic init_seq(input bit hold, input logic [AW-1:0] ca, input logic [CW-1:0] cv);
        rst = 1'b0;
        #1;
        for (int i = 0; i < NT; i++) begin
            n_checks++;
            if ({bus.busy, bus.dmem_we, bus.dmem_waddr, bus.dmem_wdata, bus.valid, bus.cload_ack, bus.cmem_we}
                !== {1'b1, 1'b1, AW'(i), DW'(0), 1'b0, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL init_clear i=%0d: got busy=%b we=%b addr=%0d data=%h valid=%b ack=%b cwe=%b, want 1 1 %0d 0 0 0 0",
                         i, bus.busy, bus.dmem_we, bus.dmem_waddr, bus.dmem_wdata, bus.valid, bus.cload_ack, bus.cmem_we, i);
            end
            step();
            #1;
        end
        n_checks++;
        if ({bus.busy, bus.dmem_we, bus.cload_ack, bus.cmem_we} !== {1'b0, 1'b0, hold, hold}) begin
            n_fail++;
            $display("FAIL init_end: got busy=%b we=%b ack=%b cwe=%b, want 0 0 %b %b",
                     bus.busy, bus.dmem_we, bus.cload_ack, bus.cmem_we, hold, hold);
        end
        if (hold) begin
            n_checks++;
            if ({bus.cmem_addr, bus.cmem_wdata} !== {ca, cv}) begin
                n_fail++;
                $display("FAIL init_cload: got addr=%0d data=%h, want %0d %h", bus.cmem_addr, bus.cmem_wdata, ca, cv);
            end
            coef_m[ca] = int'($signed(cv));
        end
        step();
        bus.cload_req = 1'b0;
        hist = {};
        for (int i = 0; i < NT; i++) hist.push_back(0);
        wptr_m = 0;
    endtask

    task automatic load_coef(input logic [AW-1:0] a, input logic [CW-1:0] v);
        bus.cload_req = 1'b1;
        bus.caddr     = a;
        bus.cin       = v;
        #1;
        n_checks++;
        if ({bus.cload_ack, bus.cmem_we, bus.cmem_addr, bus.cmem_wdata, bus.busy} !== {1'b1, 1'b1, a, v, 1'b0}) begin
            n_fail++;
            $display("FAIL cload a=%0d: got ack=%b we=%b addr=%0d data=%h busy=%b, want 1 1 %0d %h 0",
                     a, bus.cload_ack, bus.cmem_we, bus.cmem_addr, bus.cmem_wdata, bus.busy, a, v);
        end
        coef_m[a] = int'($signed(v));
        step();
        bus.cload_req = 1'b0;
    endtask

    task automatic run_sample(input logic [DW-1:0] x, input int ovr_c, input bit hold_cl,
                              input logic [AW-1:0] ca, input logic [CW-1:0] cv);
        logic [ACCW-1:0] exp_v;
        int exp_ra;
        hist.push_front(int'($signed(x)));
        void'(hist.pop_back());
        exp_v = ref_out();
        bus.sample_stb = 1'b1;
        bus.din        = x;
        if (hold_cl) begin
            bus.cload_req = 1'b1;
            bus.caddr     = ca;
            bus.cin       = cv;
        end
        #1;
        n_checks++;
        if ({bus.dmem_we, bus.dmem_waddr, bus.dmem_wdata, bus.cload_ack, bus.busy} !== {1'b1, AW'(wptr_m), x, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL accept: got we=%b addr=%0d data=%h ack=%b busy=%b, want 1 %0d %h 0 0",
                     bus.dmem_we, bus.dmem_waddr, bus.dmem_wdata, bus.cload_ack, bus.busy, wptr_m, x);
        end
        for (int c = 1; c <= LAT; c++) begin
            step();
            bus.sample_stb = (c == ovr_c);
            bus.din        = DW'($urandom);
            #1;
            n_checks++;
            if ({bus.busy, bus.overrun, bus.dmem_we, bus.valid} !== {(c < LAT), (c == ovr_c), 1'b0, (c == LAT)}) begin
                n_fail++;
                $display("FAIL ctl c=%0d: got busy=%b ovr=%b we=%b valid=%b, want %b %b 0 %b",
                         c, bus.busy, bus.overrun, bus.dmem_we, bus.valid, (c < LAT), (c == ovr_c), (c == LAT));
            end
            n_checks++;
            if ({bus.mac_en, bus.mac_clr} !== {(c >= 2 && c <= NT + 1), (c == 2)}) begin
                n_fail++;
                $display("FAIL mac_strobe c=%0d: got en=%b clr=%b, want %b %b",
                         c, bus.mac_en, bus.mac_clr, (c >= 2 && c <= NT + 1), (c == 2));
            end
            n_checks++;
            if ({bus.cload_ack, bus.cmem_we} !== {2{hold_cl && c == LAT}}) begin
                n_fail++;
                $display("FAIL cload_hold c=%0d: got ack=%b we=%b, want %b",
                         c, bus.cload_ack, bus.cmem_we, (hold_cl && c == LAT));
            end
            if (c <= NT) begin
                exp_ra = ((wptr_m - (c - 1)) % NT + NT) % NT;
                n_checks++;
                if ({bus.dmem_raddr, bus.cmem_addr} !== {AW'(exp_ra), AW'(c - 1)}) begin
                    n_fail++;
                    $display("FAIL tap_addr c=%0d: got raddr=%0d caddr=%0d, want %0d %0d",
                             c, bus.dmem_raddr, bus.cmem_addr, exp_ra, c - 1);
                end
            end
            if (c == LAT) begin
                n_checks++;
                if (bus.dout !== exp_v) begin
                    n_fail++;
                    $display("FAIL dout: got %h, want %h", bus.dout, exp_v);
                end
                if (hold_cl) begin
                    n_checks++;
                    if ({bus.cmem_addr, bus.cmem_wdata} !== {ca, cv}) begin
                        n_fail++;
                        $display("FAIL cload_late: got addr=%0d data=%h, want %0d %h", bus.cmem_addr, bus.cmem_wdata, ca, cv);
                    end
                end
            end
        end
        step();
        bus.sample_stb = 1'b0;
        bus.cload_req  = 1'b0;
        #1;
        if (hold_cl) coef_m[ca] = int'($signed(cv));
        wptr_m = (wptr_m + 1) % NT;
        n_checks++;
        if ({bus.valid, bus.dout} !== {1'b0, exp_v}) begin
            n_fail++;
            $display("FAIL dout_hold: got valid=%b dout=%h, want 0 %h", bus.valid, bus.dout, exp_v);
        end
        step();
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        bus.sample_stb = 1'b0;
        bus.din        = '0;
        bus.cload_req  = 1'b1;
        bus.caddr      = 6'd7;
        bus.cin        = 17'd1;
        step();
        #1;
        n_checks++;
        if ({bus.busy, bus.dmem_we, bus.dmem_waddr, bus.dmem_wdata, bus.dmem_raddr, bus.cmem_we, bus.cmem_addr,
             bus.cmem_wdata, bus.cload_ack, bus.mac_en, bus.mac_clr, bus.valid, bus.dout, bus.overrun} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b dwe=%b cwe=%b ack=%b valid=%b dout=%h, want all 0",
                     bus.busy, bus.dmem_we, bus.cmem_we, bus.cload_ack, bus.valid, bus.dout);
        end
        step();
        init_seq(1'b1, 6'd7, 17'd1);
    endtask

    task automatic test_cload();
        load_coef(6'd5, 17'h1ABCD);
        for (int a = 0; a < NT; a++) load_coef(AW'(a), 17'd1);
    endtask

    task automatic test_ones();
        run_sample(16'd100, 0, 1'b0, '0, '0);
        n_checks++;
        if (bus.dout !== ACCW'(100)) begin
            n_fail++;
            $display("FAIL ones_first: got %0d, want 100", bus.dout);
        end
        run_sample(16'd200, 0, 1'b0, '0, '0);
        n_checks++;
        if (bus.dout !== ACCW'(300)) begin
            n_fail++;
            $display("FAIL ones_second: got %0d, want 300", bus.dout);
        end
    endtask

    task automatic test_overrun();
        run_sample(16'd37, 11, 1'b0, '0, '0);
    endtask

    task automatic test_stb_cload();
        run_sample(16'hFFF0, 0, 1'b1, 6'd9, 17'd3);
        run_sample(16'd5, 0, 1'b0, '0, '0);
    endtask

    task automatic test_mid_reset();
        bus.sample_stb = 1'b1;
        bus.din        = 16'd999;
        step();
        bus.sample_stb = 1'b0;
        for (int c = 1; c < 31; c++) step();
        rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.busy, bus.dmem_we, bus.dmem_raddr, bus.cmem_addr, bus.mac_en, bus.mac_clr, bus.valid, bus.dout} !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got busy=%b we=%b raddr=%0d caddr=%0d en=%b valid=%b dout=%h, want all 0",
                     bus.busy, bus.dmem_we, bus.dmem_raddr, bus.cmem_addr, bus.mac_en, bus.valid, bus.dout);
        end
        step();
        init_seq(1'b0, '0, '0);
    endtask

    task automatic test_wrap_random();
        int ovr;
        for (int a = 0; a < NT; a++) load_coef(AW'(a), CW'($urandom));
        for (int n = 0; n < 70; n++) begin
            ovr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, LAT - 1)) : 0;
            run_sample(DW'($urandom), ovr, 1'b0, '0, '0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_cload();
        test_ones();
        test_overrun();
        test_stb_cload();
        test_mid_reset();
        test_wrap_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
